// File: rtl/vector_execute_unit.sv
// Multi-cycle lane-sliced vector ALU for the execute stage; holds the front end with stall until done.
// Optional build macro VEC_SATURATE_EN: ADD/SUB saturate per lane instead of wrapping.
module vector_execute_unit #(
    parameter int LANE_W          = 16,
    parameter int LANES           = 8,
    parameter int LANES_PER_CYCLE = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      flush,
    input  logic [4:0]                op,
    input  logic [LANE_W*LANES-1:0]   src_a,
    input  logic [LANE_W*LANES-1:0]   src_b,
    input  logic [4:0]                rd_in,
    output logic                      stall,
    output logic                      busy,
    output logic [LANE_W*LANES-1:0]   result,
    output logic                      result_valid,
    output logic [4:0]                rd_out
);

    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SH_W = $clog2(LANE_W);
    localparam logic [LW-1:0] LAST_CNT = LW'(LANES - LANES_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;
    vec_t            a_q, a_d;
    vec_t            b_q, b_d;
    vec_t            shadow_q, shadow_d;
    vec_t            result_q, result_d;
    logic [LANE_W-1:0] grp_res [LANES_PER_CYCLE];

    function automatic logic [LANE_W-1:0] lane_alu(input logic [4:0] f,
                                                   input logic [LANE_W-1:0] x,
                                                   input logic [LANE_W-1:0] y);
`ifdef VEC_SATURATE_EN
        logic [LANE_W:0] wide;
        wide = '0;
`endif
        lane_alu = '0;
        case (f)
`ifdef VEC_SATURATE_EN
            5'd1: begin
                wide     = {1'b0, x} + {1'b0, y};
                lane_alu = wide[LANE_W] ? '1 : wide[LANE_W-1:0];
            end
            5'd2:    lane_alu = (x < y) ? '0 : x - y;
`else
            5'd1:    lane_alu = x + y;
            5'd2:    lane_alu = x - y;
`endif
            5'd3:    lane_alu = x & y;
            5'd4:    lane_alu = x | y;
            5'd5:    lane_alu = x ^ y;
            5'd6:    lane_alu = x << y[SH_W-1:0];
            5'd7:    lane_alu = x >> y[SH_W-1:0];
            5'd8:    lane_alu = x * y;
            5'd9:    lane_alu = (x > y) ? x : y;
            5'd10:   lane_alu = (x < y) ? x : y;
            default: lane_alu = '0;
        endcase
    endfunction

    // One ALU slice per lane processed in a busy cycle, steered by the lane counter.
    generate
        for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_lane
            assign grp_res[gi] = lane_alu(op_q, a_q[cnt_q + LW'(gi)], b_q[cnt_q + LW'(gi)]);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        shadow_d = shadow_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && op != 5'd0) begin
                        state_d = ISSUE;
                        op_d    = op;
                        a_d     = src_a;
                        b_d     = src_b;
                        rd_d    = rd_in;
                        cnt_d   = '0;
                    end
                end
                ISSUE: state_d = BUSY;
                BUSY: begin
                    for (int i = 0; i < LANES_PER_CYCLE; i++) begin
                        shadow_d[cnt_q + LW'(i)] = grp_res[i];
                    end
                    cnt_d = cnt_q + LW'(LANES_PER_CYCLE);
                    // Visible result only moves on the edge into DONE, including the final group.
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        result_d = shadow_d;
                        rd_out_d = rd_q;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            shadow_q <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // In DONE the upstream register still shows the finished instruction, so it must not stall.
    assign stall        = start && (op != 5'd0) && (state_q != DONE);
    assign busy         = (state_q == ISSUE) || (state_q == BUSY);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_vector_execute_unit.sv
// Directed bench for vector_execute_unit: scoreboard of expected results checked on each result_valid.
module tb_vector_execute_unit;

    localparam int N = 4;
`ifdef VEC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [4:0]   op, rd_in, rd_out;
    logic [127:0] src_a, src_b, result;
    logic         stall, busy, result_valid;

    logic [132:0] sb [$];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] last_res;
    logic [4:0]   last_rd;

    always #5 clk = ~clk;

    vector_execute_unit dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .stall(stall), .busy(busy),
        .result(result), .result_valid(result_valid), .rd_out(rd_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [4:0] f, input logic [127:0] a,
                                           input logic [127:0] b);
        logic [127:0] r;
        longint xi, yi, v;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            xi = longint'(a[l*16 +: 16]);
            yi = longint'(b[l*16 +: 16]);
            case (f)
                5'd1:    v = SAT ? ((xi + yi > 65535) ? 65535 : xi + yi) : ((xi + yi) & 65535);
                5'd2:    v = SAT ? ((xi < yi) ? 0 : xi - yi) : ((xi - yi) & 65535);
                5'd3:    v = xi & yi;
                5'd4:    v = xi | yi;
                5'd5:    v = xi ^ yi;
                5'd6:    v = (xi << (yi % 16)) & 65535;
                5'd7:    v = xi >> (yi % 16);
                5'd8:    v = (xi * yi) & 65535;
                5'd9:    v = (xi > yi) ? xi : yi;
                5'd10:   v = (xi < yi) ? xi : yi;
                default: v = 0;
            endcase
            r[l*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one instruction from cycle 0 and checks every cycle through its DONE cycle.
    task automatic run_op(input logic [4:0] f, input logic [127:0] a, input logic [127:0] b,
                          input logic [4:0] rd);
        logic [132:0] exp;
        @(posedge clk); #1;
        start = 1'b1; op = f; src_a = a; src_b = b; rd_in = rd;
        sb.push_back({rd, model(f, a, b)});
        for (int c = 0; c <= N + 2; c++) begin
            @(negedge clk);
            chk($sformatf("op%0d_stall_c%0d", f, c), 128'(stall), 128'(c <= N + 1));
            chk($sformatf("op%0d_valid_c%0d", f, c), 128'(result_valid), 128'(c == N + 2));
            chk($sformatf("op%0d_busy_c%0d", f, c), 128'(busy), 128'(c >= 1 && c <= N + 1));
            if (c < N + 2) begin
                chk($sformatf("op%0d_res_stable_c%0d", f, c), result, last_res);
                chk($sformatf("op%0d_rd_stable_c%0d", f, c), 128'(rd_out), 128'(last_rd));
            end else begin
                if (sb.size() != 0) exp = sb.pop_front();
                else exp = 'x;
                chk($sformatf("op%0d_result", f), result, exp[127:0]);
                chk($sformatf("op%0d_rd_out", f), 128'(rd_out), 128'(exp[132:128]));
                $display("op=%0d rd=%0d result=%h", f, rd_out, result);
                last_res = exp[127:0];
                last_rd  = exp[132:128];
            end
        end
    endtask

    task automatic end_op();
        @(posedge clk); #1;
        start = 1'b0; op = '0;
        @(negedge clk);
        chk("idle_stall", 128'(stall), 128'(0));
        chk("idle_valid", 128'(result_valid), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        logic [127:0] a, b;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rd_in = '0;
        src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 128'(0));
        chk("rst_rd_out", 128'(rd_out), 128'(0));
        chk("rst_valid", 128'(result_valid), 128'(0));
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        last_res = '0;
        last_rd  = '0;

        // NOP never stalls or produces a result.
        @(posedge clk); #1 start = 1'b1; op = 5'd0;
        repeat (3) begin
            @(negedge clk);
            chk("nop_stall", 128'(stall), 128'(0));
            chk("nop_valid", 128'(result_valid), 128'(0));
        end
        end_op();

        run_op(5'd1, {8{16'h0001}}, {8{16'h0002}}, 5'd5);
        end_op();

        a = '0; b = '0;
        a[63:48] = 16'hFFFF; b[63:48] = 16'h0002;
        run_op(5'd1, a, b, 5'd6);
        end_op();
        chk("add_lane3", 128'(result[63:48]), SAT ? 128'(16'hFFFF) : 128'(16'h0001));
        chk("add_lane4", 128'(result[79:64]), 128'(0));

        a = rnd128(); b = rnd128();
        a[127:112] = 16'h0100; b[127:112] = 16'h0100;
        run_op(5'd8, a, b, 5'd7);
        end_op();
        chk("mul_lane7", 128'(result[127:112]), 128'(0));

        a = rnd128(); b = rnd128();
        a[15:0] = 16'h8000; b[15:0] = 16'd15;
        run_op(5'd7, a, b, 5'd8);
        end_op();
        chk("srl_lane0", 128'(result[15:0]), 128'(16'h0001));

        run_op(5'd1, rnd128(), rnd128(), 5'd10);
        end_op();

        // Flush in the second BUSY cycle; start held until flush lands.
        @(posedge clk); #1;
        start = 1'b1; op = 5'd2; src_a = rnd128(); src_b = rnd128(); rd_in = 5'd11;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", 128'(busy), 128'(1));
        @(posedge clk); #1 flush = 1'b0; start = 1'b0; op = '0;
        @(negedge clk);
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_stall", 128'(stall), 128'(0));
        chk("flush_result", result, last_res);
        chk("flush_rd", 128'(rd_out), 128'(last_rd));
        repeat (8) begin
            @(negedge clk);
            chk("flush_no_valid", 128'(result_valid), 128'(0));
        end

        // Back-to-back: new op presented right after DONE.
        run_op(5'd2, rnd128(), rnd128(), 5'd12);
        run_op(5'd5, rnd128(), rnd128(), 5'd13);
        end_op();
        repeat (6) begin
            @(negedge clk);
            chk("b2b_no_extra_valid", 128'(result_valid), 128'(0));
        end

        begin
            logic [4:0] ops [8] = '{5'd3, 5'd4, 5'd6, 5'd9, 5'd10, 5'd8, 5'd12, 5'd31};
            for (int k = 0; k < 8; k++) begin
                a = rnd128(); b = rnd128();
                b[31:16] = a[31:16];
                run_op(ops[k], a, b, 5'(14 + k));
                end_op();
            end
        end

        // Reset mid-operation clears outputs.
        @(posedge clk); #1;
        start = 1'b1; op = 5'd1; src_a = rnd128(); src_b = rnd128(); rd_in = 5'd30;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1; start = 1'b0; op = '0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_result", result, 128'(0));
        chk("rst2_rd", 128'(rd_out), 128'(0));
        chk("rst2_busy", 128'(busy), 128'(0));
        chk("rst2_valid", 128'(result_valid), 128'(0));
        last_res = '0;
        last_rd  = '0;
        run_op(5'd1, rnd128(), rnd128(), 5'd31);
        end_op();

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
